// File: rtl/bean_regfile_mb_pkg.sv
// Shared types and helpers for the BEAN multi-bank register file.
// A select is {bank, index}; the helpers split it for any index width.
package bean_reg_pkg;

    localparam int REG_BANK_X = 0;
    localparam int REG_BANK_F = 1;
    localparam int REG_BANK_I = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } reg_state_t;

    // Bank field of a select; callers truncate the result to their bank width.
    function automatic logic [31:0] sel_bank(input logic [31:0] sel, input int aw);
        return sel >> aw;
    endfunction

    // Index field of a select; callers truncate the result to their index width.
    function automatic logic [31:0] sel_idx(input logic [31:0] sel, input int aw);
        return sel & ((32'd1 << aw) - 32'd1);
    endfunction

endpackage

// File: rtl/bean_regfile_mb_if.sv
// Decode/execute-facing bus of the register file.
// Handshake: req_valid[i] sampled on a rising edge yields finish[i]=1 and the
// read data one edge later; there is no back-pressure. rd_we[i] commits on the
// edge it is sampled. busy=1 means the clear sequence owns the array.
interface bean_regfile_mb_if #(
    parameter int XLEN  = 32,
    parameter int NBANK = 2,
    parameter int DEPTH = 32,
    parameter int NCH   = 2
);
    import bean_reg_pkg::*;

    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int SW = BW + AW;

    logic [NCH-1:0]      req_valid;
    logic [NCH*SW-1:0]   rs1_sel;
    logic [NCH*SW-1:0]   rs2_sel;
    logic [NCH*SW-1:0]   rs3_sel;
    logic [NCH-1:0]      rd_we;
    logic [NCH*SW-1:0]   rd_sel;
    logic [NCH*XLEN-1:0] rd_data;
    logic [NCH*XLEN-1:0] rs1_data;
    logic [NCH*XLEN-1:0] rs2_data;
    logic [NCH*XLEN-1:0] rs3_data;
    logic [NCH-1:0]      finish;
    logic                busy;
    logic                error;
    reg_state_t          dbg_state;

    modport master (
        output req_valid, rs1_sel, rs2_sel, rs3_sel, rd_we, rd_sel, rd_data,
        input  rs1_data, rs2_data, rs3_data, finish, busy, error, dbg_state
    );

    modport slave (
        input  req_valid, rs1_sel, rs2_sel, rs3_sel, rd_we, rd_sel, rd_data,
        output rs1_data, rs2_data, rs3_data, finish, busy, error, dbg_state
    );

endinterface

// File: rtl/bean_regfile_mb_bank.sv
// One register bank: DEPTH x XLEN storage, NWR write ports (highest port wins
// on a shared index), NRD asynchronous read ports and a synchronous clear port
// that takes precedence over all writes.
module bean_reg_bank #(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 32,
    parameter  int NWR   = 2,
    parameter  int NRD   = 6,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                i_clr_en,
    input  logic [AW-1:0]       i_clr_idx,
    input  logic [NWR-1:0]      i_we,
    input  logic [NWR*AW-1:0]   i_wr_idx,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    input  logic [NRD*AW-1:0]   i_rd_idx,
    output logic [NRD*XLEN-1:0] o_rd_data
);

    logic [XLEN-1:0] r_mem [DEPTH];

    // Storage update: clear sweep first, otherwise channel writes in ascending priority.
    always_ff @(posedge clk) begin
        if (i_clr_en) begin
            r_mem[i_clr_idx] <= '0;
        end else begin
            for (int c = 0; c < NWR; c++) begin
                if (i_we[c]) r_mem[i_wr_idx[c*AW +: AW]] <= i_wr_data[c*XLEN +: XLEN];
            end
        end
    end

    // Asynchronous read ports.
    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            o_rd_data[k*XLEN +: XLEN] = r_mem[i_rd_idx[k*AW +: AW]];
        end
    end

endmodule

// File: rtl/bean_regfile_mb.sv
// BEAN multi-bank, multi-channel register file top level: clear sequencer,
// write qualification, bypass/priority read muxing, error detection and the
// registered read outputs. Read port k of the flattened set is channel k/3,
// operand k%3 (rs1, rs2, rs3).
module bean_regfile_mb
    import bean_reg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NBANK = 2,
    parameter int DEPTH = 32,
    parameter int NCH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    bean_regfile_mb_if.slave  bus
);

    localparam int BW  = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int SW  = BW + AW;
    localparam int NRP = 3 * NCH;

    reg_state_t          r_state;
    logic [AW-1:0]       r_cnt;
    logic [NCH-1:0]      r_finish;
    logic                r_error;
    logic [XLEN-1:0]     r_rs [NRP];

    logic [BW-1:0]       w_wbank [NCH];
    logic [NCH-1:0]      w_wr_ok;
    logic [NCH*AW-1:0]   w_wr_idx;
    logic                w_err_wr;
    logic [NCH-1:0]      w_bank_we [NBANK];
    logic [SW-1:0]       w_rsel [NRP];
    logic [BW-1:0]       w_rbank [NRP];
    logic [NRP*AW-1:0]   w_rd_idx;
    logic [NRP*XLEN-1:0] w_bank_rd [NBANK];
    logic [XLEN-1:0]     w_rval [NRP];
    logic                w_err_rd;
    logic                w_clr;

    assign w_clr = (r_state == ST_CLEAR);

    // Flatten the three operand selects per channel and expose the read registers.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign w_rsel[3*c+0] = bus.rs1_sel[c*SW +: SW];
        assign w_rsel[3*c+1] = bus.rs2_sel[c*SW +: SW];
        assign w_rsel[3*c+2] = bus.rs3_sel[c*SW +: SW];
        assign bus.rs1_data[c*XLEN +: XLEN] = r_rs[3*c+0];
        assign bus.rs2_data[c*XLEN +: XLEN] = r_rs[3*c+1];
        assign bus.rs3_data[c*XLEN +: XLEN] = r_rs[3*c+2];
    end

    // Write qualification: drop writes during clear, to bad banks and to x0; flag conflicts.
    always_comb begin
        w_err_wr = 1'b0;
        w_wr_ok  = '0;
        w_wr_idx = '0;
        for (int c = 0; c < NCH; c++) begin
            w_wbank[c] = BW'(sel_bank(32'(bus.rd_sel[c*SW +: SW]), AW));
            w_wr_idx[c*AW +: AW] = AW'(sel_idx(32'(bus.rd_sel[c*SW +: SW]), AW));
            if (bus.rd_we[c]) begin
                if (w_clr || (32'(w_wbank[c]) >= NBANK)) w_err_wr = 1'b1;
                else if (bus.rd_sel[c*SW +: SW] != '0) w_wr_ok[c] = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            for (int j = i + 1; j < NCH; j++) begin
                if (w_wr_ok[i] && w_wr_ok[j] &&
                    (bus.rd_sel[i*SW +: SW] == bus.rd_sel[j*SW +: SW])) w_err_wr = 1'b1;
            end
        end
    end

    // Route each qualified write to the bank its select names.
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            for (int c = 0; c < NCH; c++) begin
                w_bank_we[b][c] = w_wr_ok[c] && (w_wbank[c] == BW'(b));
            end
        end
    end

    // Split read selects into bank and index; all banks see the same indices.
    always_comb begin
        w_rd_idx = '0;
        for (int k = 0; k < NRP; k++) begin
            w_rbank[k] = BW'(sel_bank(32'(w_rsel[k]), AW));
            w_rd_idx[k*AW +: AW] = AW'(sel_idx(32'(w_rsel[k]), AW));
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        bean_reg_bank #(
            .XLEN  (XLEN),
            .DEPTH (DEPTH),
            .NWR   (NCH),
            .NRD   (NRP)
        ) u_bank (
            .clk       (clk),
            .i_clr_en  (w_clr),
            .i_clr_idx (r_cnt),
            .i_we      (w_bank_we[b]),
            .i_wr_idx  (w_wr_idx),
            .i_wr_data (bus.rd_data),
            .i_rd_idx  (w_rd_idx),
            .o_rd_data (w_bank_rd[b])
        );
    end

    // Read value: bank array, overridden by same-cycle writes (highest channel last), then x0/bad-bank zeroing.
    always_comb begin
        w_err_rd = 1'b0;
        for (int k = 0; k < NRP; k++) begin
            w_rval[k] = '0;
            for (int b = 0; b < NBANK; b++) begin
                if (w_rbank[k] == BW'(b)) w_rval[k] = w_bank_rd[b][k*XLEN +: XLEN];
            end
            for (int c = 0; c < NCH; c++) begin
                if (w_wr_ok[c] && (bus.rd_sel[c*SW +: SW] == w_rsel[k]))
                    w_rval[k] = bus.rd_data[c*XLEN +: XLEN];
            end
            if (32'(w_rbank[k]) >= NBANK) begin
                w_rval[k] = '0;
                if ((r_state == ST_RUN) && bus.req_valid[k/3]) w_err_rd = 1'b1;
            end
            if (w_rsel[k] == '0) w_rval[k] = '0;
        end
    end

    // Clear/run sequencer together with the registered read, finish and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_CLEAR;
            r_cnt    <= '0;
            r_finish <= '0;
            r_error  <= 1'b0;
            for (int k = 0; k < NRP; k++) r_rs[k] <= '0;
        end else begin
            r_error <= w_err_wr | w_err_rd;
            case (r_state)
                ST_CLEAR: begin
                    r_finish <= '0;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == AW'(DEPTH - 1)) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    for (int c = 0; c < NCH; c++) begin
                        r_finish[c] <= bus.req_valid[c];
                        if (bus.req_valid[c]) begin
                            for (int p = 0; p < 3; p++) r_rs[3*c+p] <= w_rval[3*c+p];
                        end
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign bus.finish    = r_finish;
    assign bus.busy      = (r_state == ST_CLEAR);
    assign bus.error     = r_error;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_bean_regfile_mb.sv
// Directed bench for bean_regfile_mb: a two-bank build (bus0) and a three-bank
// build (bus3) sharing clock and reset. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_bean_regfile_mb;
  import bean_reg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bean_regfile_mb_if #(.XLEN(32), .NBANK(2), .DEPTH(32), .NCH(2)) bus0();
  bean_regfile_mb_if #(.XLEN(32), .NBANK(3), .DEPTH(32), .NCH(2)) bus3();

  bean_regfile_mb #(.XLEN(32), .NBANK(2), .DEPTH(32), .NCH(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  bean_regfile_mb #(.XLEN(32), .NBANK(3), .DEPTH(32), .NCH(2)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.req_valid = '0; bus0.rs1_sel = '0; bus0.rs2_sel = '0; bus0.rs3_sel = '0;
    bus0.rd_we = '0; bus0.rd_sel = '0; bus0.rd_data = '0;
    bus3.req_valid = '0; bus3.rs1_sel = '0; bus3.rs2_sel = '0; bus3.rs3_sel = '0;
    bus3.rd_we = '0; bus3.rd_sel = '0; bus3.rd_data = '0;
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus0.rs1_data, bus0.rs2_data, bus0.rs3_data} !== '0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {bus0.rs1_data, bus0.rs2_data, bus0.rs3_data});
    end
    checks++;
    if (bus0.finish !== 2'b00 || bus0.error !== 1'b0) begin
      failures++; $display("FAIL reset_flags got finish=%b error=%b exp 00/0", bus0.finish, bus0.error);
    end
    checks++;
    if (bus0.busy !== 1'b1) begin
      failures++; $display("FAIL reset_busy got=%b exp=1", bus0.busy);
    end
    rst = 1'b0;
    n = 0;
    while (bus0.busy === 1'b1 && n < 100) begin
      bus0.req_valid = 2'b11;
      if (n == 20) begin
        bus0.rd_we = 2'b01; bus0.rd_sel = 12'd1; bus0.rd_data = 64'h0000_ABCD;
      end else begin
        bus0.rd_we = 2'b00;
      end
      tick();
      n++;
      if (n == 10) begin
        checks++;
        if (bus0.finish !== 2'b00) begin
          failures++; $display("FAIL busy_finish got=%b exp=00", bus0.finish);
        end
      end
      if (n == 21) begin
        checks++;
        if (bus0.error !== 1'b1) begin
          failures++; $display("FAIL busy_write_err got=%b exp=1", bus0.error);
        end
      end
      if (n == 22) begin
        checks++;
        if (bus0.error !== 1'b0) begin
          failures++; $display("FAIL busy_err_pulse got=%b exp=0", bus0.error);
        end
      end
    end
    idle();
    checks++;
    if (n != 32) begin
      failures++; $display("FAIL busy_cycles got=%0d exp=32", n);
    end
    checks++;
    if (bus0.dbg_state !== ST_RUN) begin
      failures++; $display("FAIL run_state got=%0d exp=%0d", bus0.dbg_state, ST_RUN);
    end
    for (int a = 0; a < 64; a += 6) begin
      bus0.req_valid = 2'b11;
      bus0.rs1_sel = {6'((a + 3) % 64), 6'(a % 64)};
      bus0.rs2_sel = {6'((a + 4) % 64), 6'((a + 1) % 64)};
      bus0.rs3_sel = {6'((a + 5) % 64), 6'((a + 2) % 64)};
      tick();
      checks++;
      if ({bus0.rs1_data, bus0.rs2_data, bus0.rs3_data} !== '0 || bus0.finish !== 2'b11) begin
        failures++;
        $display("FAIL clear_read base=%0d got data=%h finish=%b exp 0/11", a,
                 {bus0.rs1_data, bus0.rs2_data, bus0.rs3_data}, bus0.finish);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    idle();
    bus0.rd_we = 2'b01; bus0.rd_sel = 12'd5; bus0.rd_data = 64'h0000_0000_DEAD_BEEF;
    tick();
    checks++;
    if (bus0.error !== 1'b0) begin
      failures++; $display("FAIL wr_noerr got=%b exp=0", bus0.error);
    end
    idle();
    bus0.req_valid = 2'b10; bus0.rs1_sel = {6'd5, 6'd0};
    tick();
    checks++;
    if (bus0.rs1_data[63:32] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL rd_x5_data got=%h exp=deadbeef", bus0.rs1_data[63:32]);
    end
    checks++;
    if (bus0.finish !== 2'b10) begin
      failures++; $display("FAIL rd_x5_finish got=%b exp=10", bus0.finish);
    end
    idle();
    tick();
    checks++;
    if (bus0.finish !== 2'b00 || bus0.rs1_data[63:32] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL idle_hold got finish=%b data=%h exp 00/deadbeef", bus0.finish, bus0.rs1_data[63:32]);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus0.rd_we = 2'b01; bus0.rd_sel = {6'd0, 6'd35}; bus0.rd_data = {32'd0, 32'h1234};
    bus0.req_valid = 2'b11; bus0.rs2_sel = {6'd0, 6'd35}; bus0.rs3_sel = {6'd35, 6'd0};
    tick();
    checks++;
    if (bus0.rs2_data[31:0] !== 32'h1234) begin
      failures++; $display("FAIL bypass_same_ch got=%h exp=1234", bus0.rs2_data[31:0]);
    end
    checks++;
    if (bus0.rs3_data[63:32] !== 32'h1234) begin
      failures++; $display("FAIL bypass_cross_ch got=%h exp=1234", bus0.rs3_data[63:32]);
    end
    checks++;
    if (bus0.error !== 1'b0) begin
      failures++; $display("FAIL bypass_noerr got=%b exp=0", bus0.error);
    end
    idle();
  endtask

  task automatic test_conflict();
    idle();
    bus0.rd_we = 2'b11; bus0.rd_sel = {6'd7, 6'd7}; bus0.rd_data = {32'h2, 32'h1};
    bus0.req_valid = 2'b01; bus0.rs1_sel = {6'd0, 6'd7};
    tick();
    checks++;
    if (bus0.error !== 1'b1) begin
      failures++; $display("FAIL conflict_err got=%b exp=1", bus0.error);
    end
    checks++;
    if (bus0.rs1_data[31:0] !== 32'h2) begin
      failures++; $display("FAIL conflict_bypass got=%h exp=2", bus0.rs1_data[31:0]);
    end
    idle();
    bus0.req_valid = 2'b10; bus0.rs2_sel = {6'd7, 6'd0};
    tick();
    checks++;
    if (bus0.error !== 1'b0) begin
      failures++; $display("FAIL conflict_pulse got=%b exp=0", bus0.error);
    end
    checks++;
    if (bus0.rs2_data[63:32] !== 32'h2) begin
      failures++; $display("FAIL conflict_winner got=%h exp=2", bus0.rs2_data[63:32]);
    end
    idle();
    bus0.rd_we = 2'b11; bus0.rd_sel = {6'd9, 6'd8}; bus0.rd_data = {32'hB, 32'hA};
    tick();
    checks++;
    if (bus0.error !== 1'b0) begin
      failures++; $display("FAIL parallel_noerr got=%b exp=0", bus0.error);
    end
    idle();
    bus0.req_valid = 2'b01; bus0.rs1_sel = {6'd0, 6'd8}; bus0.rs3_sel = {6'd0, 6'd9};
    tick();
    checks++;
    if (bus0.rs1_data[31:0] !== 32'hA || bus0.rs3_data[31:0] !== 32'hB) begin
      failures++; $display("FAIL parallel_data got=%h/%h exp=a/b", bus0.rs1_data[31:0], bus0.rs3_data[31:0]);
    end
    idle();
  endtask

  task automatic test_x0();
    idle();
    bus0.rd_we = 2'b01; bus0.rd_sel = 12'd0; bus0.rd_data = 64'h0000_FFFF;
    bus0.req_valid = 2'b01; bus0.rs1_sel = 12'd0;
    tick();
    checks++;
    if (bus0.error !== 1'b0) begin
      failures++; $display("FAIL x0_noerr got=%b exp=0", bus0.error);
    end
    checks++;
    if (bus0.rs1_data[31:0] !== 32'h0) begin
      failures++; $display("FAIL x0_read got=%h exp=0", bus0.rs1_data[31:0]);
    end
    idle();
    bus0.rd_we = 2'b10; bus0.rd_sel = {6'd32, 6'd0}; bus0.rd_data = {32'h55, 32'h0};
    tick();
    idle();
    bus0.req_valid = 2'b10; bus0.rs1_sel = {6'd32, 6'd0}; bus0.rs2_sel = 12'd0;
    tick();
    checks++;
    if (bus0.rs1_data[63:32] !== 32'h55) begin
      failures++; $display("FAIL f0_read got=%h exp=55", bus0.rs1_data[63:32]);
    end
    checks++;
    if (bus0.rs2_data[63:32] !== 32'h0) begin
      failures++; $display("FAIL x0_after_write got=%h exp=0", bus0.rs2_data[63:32]);
    end
    idle();
  endtask

  task automatic test_bad_bank();
    idle();
    bus3.rd_we = 2'b01; bus3.rd_sel = {7'd0, 7'd66}; bus3.rd_data = {32'd0, 32'h77};
    tick();
    checks++;
    if (bus3.error !== 1'b0) begin
      failures++; $display("FAIL bank_i_wr_noerr got=%b exp=0", bus3.error);
    end
    idle();
    bus3.req_valid = 2'b01; bus3.rs1_sel = {7'd0, 7'd66};
    tick();
    checks++;
    if (bus3.rs1_data[31:0] !== 32'h77) begin
      failures++; $display("FAIL bank_i_read got=%h exp=77", bus3.rs1_data[31:0]);
    end
    idle();
    bus3.req_valid = 2'b01; bus3.rs1_sel = {7'd0, 7'h64};
    tick();
    checks++;
    if (bus3.rs1_data[31:0] !== 32'h0 || bus3.finish !== 2'b01) begin
      failures++; $display("FAIL bad_read got data=%h finish=%b exp 0/01", bus3.rs1_data[31:0], bus3.finish);
    end
    checks++;
    if (bus3.error !== 1'b1) begin
      failures++; $display("FAIL bad_read_err got=%b exp=1", bus3.error);
    end
    idle();
    tick();
    checks++;
    if (bus3.error !== 1'b0) begin
      failures++; $display("FAIL bad_err_pulse got=%b exp=0", bus3.error);
    end
    idle();
    bus3.rd_we = 2'b10; bus3.rd_sel = {7'h64, 7'd0}; bus3.rd_data = {32'h99, 32'h0};
    tick();
    checks++;
    if (bus3.error !== 1'b1) begin
      failures++; $display("FAIL bad_write_err got=%b exp=1", bus3.error);
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    int n;
    idle();
    bus0.req_valid = 2'b10; bus0.rs1_sel = {6'd5, 6'd0};
    tick();
    checks++;
    if (bus0.rs1_data[63:32] !== 32'hDEAD_BEEF || bus0.finish !== 2'b10) begin
      failures++; $display("FAIL pre_rst_read got data=%h finish=%b exp deadbeef/10", bus0.rs1_data[63:32], bus0.finish);
    end
    idle();
    rst = 1'b1;
    #2;
    checks++;
    if (bus0.rs1_data !== '0 || bus0.finish !== 2'b00) begin
      failures++; $display("FAIL rst_async_out got data=%h finish=%b exp 0/00", bus0.rs1_data, bus0.finish);
    end
    checks++;
    if (bus0.busy !== 1'b1) begin
      failures++; $display("FAIL rst_async_busy got=%b exp=1", bus0.busy);
    end
    tick();
    rst = 1'b0;
    n = 0;
    while (bus0.busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 32) begin
      failures++; $display("FAIL reclear_cycles got=%0d exp=32", n);
    end
    bus0.req_valid = 2'b10; bus0.rs1_sel = {6'd5, 6'd0};
    tick();
    checks++;
    if (bus0.rs1_data[63:32] !== 32'h0 || bus0.finish !== 2'b10) begin
      failures++; $display("FAIL reclear_x5 got data=%h finish=%b exp 0/10", bus0.rs1_data[63:32], bus0.finish);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_conflict();
    test_x0();
    test_bad_bank();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
